mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, 2, max accepted-but-unanswered bus transactions (1..4).
REQ-002 Parameter STARVE_LIMIT, 4, max consecutive contested grants to data port before fetch port wins (1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 i_req / i_addr  input  1/32  fetch port request and word address.
REQ-006 i_gnt / i_rvalid / i_err  output  1/1/1  fetch port grant, response valid, response error.
REQ-007 i_rdata  output  32  fetch port read data.
REQ-008 d_req / d_we / d_be / d_addr / d_wdata  input  1/1/4/32/32  LSU port request, write enable, byte enables, address, write data.
REQ-009 d_gnt / d_rvalid / d_err  output  1/1/1  LSU port grant, response valid, response error.
REQ-010 d_rdata  output  32  LSU port read data.
REQ-011 m_req / m_we / m_be / m_addr / m_wdata  output  1/1/4/32/32  shared bus request and address-phase fields.
REQ-012 m_gnt / m_rvalid / m_err / m_rdata  input  1/1/1/32  shared bus grant, in-order response valid, error, read data.
REQ-013 busy  output  1  high while any transaction is outstanding or an address phase is pending.

Function
REQ-014 Address phase: transfer occurs on a cycle with m_req=1 and m_gnt=1; the granted master sees x_gnt=1 in that same cycle, combinationally from m_gnt.
REQ-015 Owner selection: data port wins when d_req=1, unless a starvation override is active; otherwise fetch port wins when i_req=1.
REQ-016 Lock: while m_req=1 and m_gnt=0, owner and all m_* address-phase fields stay frozen; new requests cannot preempt.
REQ-017 Lock release: the cycle after the transfer, or when the locked owner drops its req.
REQ-018 m_req shall be 0 when outstanding count equals MAX_OUTSTANDING, unless the same cycle's m_rvalid frees a slot.
REQ-019 m_we/m_be/m_wdata: from data port when it owns; m_we=0, m_be=4'hF, m_wdata=0 when fetch owns.
REQ-020 Tag FIFO: depth MAX_OUTSTANDING, 1 bit per entry (0=fetch, 1=data); push on address transfer, pop on m_rvalid.
REQ-021 Simultaneous push and pop keep the count unchanged; pointers wrap modulo MAX_OUTSTANDING.
REQ-022 Response routing: on m_rvalid, assert i_rvalid or d_rvalid per FIFO head tag, same cycle; forward m_rdata and m_err to that port.
REQ-023 Non-selected port rvalid/err=0 and rdata=0.
REQ-024 m_rvalid with an empty FIFO is ignored: no rvalid to either port and no state change.
REQ-025 Starvation counter, 4 bits: increments on each data transfer while i_req=1; clears on any fetch transfer or when i_req=0; saturates at STARVE_LIMIT.
REQ-026 Override: when the counter equals STARVE_LIMIT and no lock is held, the fetch port wins the next selection.
REQ-027 busy = (FIFO count != 0) or m_req.

Reset
REQ-028 On reset_n=0, asynchronously: FIFO empty with pointers 0, starvation counter 0, lock clear.
REQ-029 During reset all port outputs are 0 (m_req, i_gnt, d_gnt, i_rvalid, d_rvalid, busy); reset mid-transaction discards all outstanding tags.

Verification
REQ-030 i_req=1 with i_addr=0x100, m_gnt=1 -> m_addr=0x100, i_gnt=1 same cycle; m_rvalid=1 with m_rdata=0xDEADBEEF the next cycle -> i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
REQ-031 i_req and d_req both held high, m_gnt=1 always, STARVE_LIMIT=4 -> grants D,D,D,D,I,D,D,D,D,I.
REQ-032 d_req=1, d_we=1, d_addr=0x2000, m_gnt=0 for 3 cycles; i_req rises in cycle 2 -> m_addr stays 0x2000 and m_we stays 1 until transfer, then fetch is served.
REQ-033 MAX_OUTSTANDING=2; two transfers with no m_rvalid -> m_req=0 while a third request waits; one m_rvalid -> m_req=1 that cycle; responses route in issue order.
REQ-034 Data transfer with m_err=1 on response -> d_rvalid=1, d_err=1, i_err=0; m_rvalid with empty FIFO -> no port rvalid.
REQ-035 reset_n asserted with 2 transactions outstanding -> busy=0 immediately; after release, a fresh fetch request completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates a fetch port (i_*) and an LSU data port (d_*) onto one
//   pipelined memory bus (m_*) that has in-order responses.
//   - clk, reset_n        : clock, asynchronous active-low reset
//   - i_req/i_addr        : fetch request; i_gnt/i_rvalid/i_err/i_rdata back
//   - d_req/d_we/d_be/
//     d_addr/d_wdata      : LSU request; d_gnt/d_rvalid/d_err/d_rdata back
//   - m_req/m_we/m_be/
//     m_addr/m_wdata      : shared bus address phase; m_gnt accepts it
//   - m_rvalid/m_err/
//     m_rdata             : shared bus response, routed via a tag FIFO
//   - busy                : transactions outstanding or address phase pending
module mem_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic        m_err,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] PTR_LAST   = PW'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]    CNT_FULL   = 3'(MAX_OUTSTANDING);
  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    LK_IDLE,
    LK_FETCH,
    LK_DATA
  } lock_e;

  lock_e                      lock_q, lock_d;
  logic                       cap_we_q, cap_we_d;
  logic [3:0]                 cap_be_q, cap_be_d;
  logic [31:0]                cap_addr_q, cap_addr_d;
  logic [31:0]                cap_wdata_q, cap_wdata_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [3:0]                 starve_q, starve_d;

  logic lock_held;
  logic override;
  logic own_data;
  logic any_req;
  logic push;
  logic pop;
  logic head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Owner selection, address-phase fields, grants and response routing
  always_comb begin
    // The lock only holds while its owner keeps requesting; a dropped
    // request releases it in the same cycle so the other port can go.
    lock_held = ((lock_q == LK_FETCH) && i_req) || ((lock_q == LK_DATA) && d_req);
    override  = i_req && (starve_q == STARVE_MAX);

    if (lock_held) own_data = (lock_q == LK_DATA);
    else           own_data = d_req && !override;

    any_req = i_req || d_req;
    pop     = m_rvalid && (cnt_q != '0);
    // Gated by reset_n so the bus sees no request while in reset.
    m_req   = reset_n && any_req && ((cnt_q != CNT_FULL) || pop);
    push    = m_req && m_gnt;

    m_we    = 1'b0;
    m_be    = 4'hF;
    m_addr  = i_addr;
    m_wdata = '0;
    if (lock_held) begin
      m_we    = cap_we_q;
      m_be    = cap_be_q;
      m_addr  = cap_addr_q;
      m_wdata = cap_wdata_q;
    end else if (own_data) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end

    i_gnt = push && !own_data;
    d_gnt = push && own_data;

    head_data = tag_q[rd_ptr_q];
    i_rvalid  = pop && !head_data;
    d_rvalid  = pop && head_data;
    i_err     = i_rvalid && m_err;
    d_err     = d_rvalid && m_err;
    i_rdata   = i_rvalid ? m_rdata : '0;
    d_rdata   = d_rvalid ? m_rdata : '0;

    busy = (cnt_q != '0) || m_req;
  end

  // Next-state: lock, captured fields, tag FIFO, starvation counter
  always_comb begin
    lock_d      = LK_IDLE;
    cap_we_d    = cap_we_q;
    cap_be_d    = cap_be_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    // Re-capturing the presented fields every stalled cycle is harmless:
    // once locked they are the captured values themselves.
    if (m_req && !m_gnt) begin
      lock_d      = own_data ? LK_DATA : LK_FETCH;
      cap_we_d    = m_we;
      cap_be_d    = m_be;
      cap_addr_d  = m_addr;
      cap_wdata_d = m_wdata;
    end

    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      tag_d[wr_ptr_q] = own_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};

    starve_d = starve_q;
    if (!i_req)                                    starve_d = '0;
    else if (push && !own_data)                    starve_d = '0;
    else if (d_gnt && (starve_q != STARVE_MAX))    starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q      <= LK_IDLE;
      cap_we_q    <= 1'b0;
      cap_be_q    <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
    end else begin
      lock_q      <= lock_d;
      cap_we_q    <= cap_we_d;
      cap_be_q    <= cap_be_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Directed table of per-cycle vectors for mem_bus_arbiter (default
//   parameters MAX_OUTSTANDING=2, STARVE_LIMIT=4) plus hand sequences for
//   starvation, lock release by request drop, and reset mid-transaction.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic        m_err;
    logic [31:0] m_rdata;
  } in_t;

  typedef struct packed {
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        i_gnt;
    logic        i_rvalid;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        busy;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  want;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_OUTSTANDING(2),
    .STARVE_LIMIT   (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_gnt   (i_gnt),
    .i_rvalid(i_rvalid),
    .i_err   (i_err),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_gnt   (d_gnt),
    .d_rvalid(d_rvalid),
    .d_err   (d_err),
    .d_rdata (d_rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_gnt   (m_gnt),
    .m_rvalid(m_rvalid),
    .m_err   (m_err),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  task automatic drive(input in_t s);
    i_req    = s.i_req;
    i_addr   = s.i_addr;
    d_req    = s.d_req;
    d_we     = s.d_we;
    d_be     = s.d_be;
    d_addr   = s.d_addr;
    d_wdata  = s.d_wdata;
    m_gnt    = s.m_gnt;
    m_rvalid = s.m_rvalid;
    m_err    = s.m_err;
    m_rdata  = s.m_rdata;
  endtask

  function automatic out_t observe();
    out_t o;
    o.m_req    = m_req;
    o.m_addr   = m_addr;
    o.m_we     = m_we;
    o.m_be     = m_be;
    o.m_wdata  = m_wdata;
    o.i_gnt    = i_gnt;
    o.i_rvalid = i_rvalid;
    o.i_err    = i_err;
    o.i_rdata  = i_rdata;
    o.d_gnt    = d_gnt;
    o.d_rvalid = d_rvalid;
    o.d_err    = d_err;
    o.d_rdata  = d_rdata;
    o.busy     = busy;
    return o;
  endfunction

  // Address-phase fields carry no meaning without m_req.
  function automatic out_t mask(input out_t o, input logic en);
    if (!en) begin
      o.m_addr  = '0;
      o.m_we    = 1'b0;
      o.m_be    = '0;
      o.m_wdata = '0;
    end
    return o;
  endfunction

  task automatic check(input string n, input out_t e);
    out_t a;
    out_t w;
    w = mask(e, e.m_req);
    a = mask(observe(), e.m_req);
    n_cmp++;
    if (a !== w) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, a, w);
    end
  endtask

  task automatic step(input string n, input in_t s, input out_t e);
    @(negedge clk);
    drive(s);
    #2;
    check(n, e);
  endtask

  task automatic add(input string n, input in_t s, input out_t e);
    vec_t v;
    v.name = n;
    v.stim = s;
    v.want = e;
    vecs.push_back(v);
  endtask

  initial begin
    string grants;
    logic [1:0] g_want;

    // Fetch read, response routed back to fetch
    add("fetch_addr", '{i_req:1'b1, i_addr:32'h100, m_gnt:1'b1, default:'0},
        '{m_req:1'b1, m_addr:32'h100, m_be:4'hF, i_gnt:1'b1, busy:1'b1, default:'0});
    add("fetch_resp", '{m_rvalid:1'b1, m_rdata:32'hDEADBEEF, default:'0},
        '{i_rvalid:1'b1, i_rdata:32'hDEADBEEF, busy:1'b1, default:'0});
    add("idle_0", '{default:'0}, '{default:'0});
    // Data read with error response, then a stray response
    add("data_addr", '{d_req:1'b1, d_be:4'hF, d_addr:32'h3000, m_gnt:1'b1, default:'0},
        '{m_req:1'b1, m_addr:32'h3000, m_be:4'hF, d_gnt:1'b1, busy:1'b1, default:'0});
    add("data_err", '{m_rvalid:1'b1, m_err:1'b1, m_rdata:32'h12345678, default:'0},
        '{d_rvalid:1'b1, d_err:1'b1, d_rdata:32'h12345678, busy:1'b1, default:'0});
    add("stray_rvalid", '{m_rvalid:1'b1, m_rdata:32'hAAAA, default:'0}, '{default:'0});
    add("idle_1", '{default:'0}, '{default:'0});
    // Stalled data write keeps its fields frozen while fetch waits
    add("lock_0", '{d_req:1'b1, d_we:1'b1, d_be:4'h3, d_addr:32'h2000, d_wdata:32'hCAFE, default:'0},
        '{m_req:1'b1, m_addr:32'h2000, m_we:1'b1, m_be:4'h3, m_wdata:32'hCAFE, busy:1'b1, default:'0});
    add("lock_1", '{i_req:1'b1, i_addr:32'h400, d_req:1'b1, d_we:1'b1, d_be:4'h3, d_addr:32'h2004,
                    d_wdata:32'hCAFE, default:'0},
        '{m_req:1'b1, m_addr:32'h2000, m_we:1'b1, m_be:4'h3, m_wdata:32'hCAFE, busy:1'b1, default:'0});
    add("lock_2", '{i_req:1'b1, i_addr:32'h400, d_req:1'b1, d_we:1'b1, d_be:4'h3, d_addr:32'h2004,
                    d_wdata:32'hCAFE, default:'0},
        '{m_req:1'b1, m_addr:32'h2000, m_we:1'b1, m_be:4'h3, m_wdata:32'hCAFE, busy:1'b1, default:'0});
    add("lock_xfer", '{i_req:1'b1, i_addr:32'h400, d_req:1'b1, d_we:1'b1, d_be:4'h3, d_addr:32'h2004,
                       d_wdata:32'hCAFE, m_gnt:1'b1, default:'0},
        '{m_req:1'b1, m_addr:32'h2000, m_we:1'b1, m_be:4'h3, m_wdata:32'hCAFE, d_gnt:1'b1, busy:1'b1,
          default:'0});
    add("fetch_after", '{i_req:1'b1, i_addr:32'h400, d_wdata:32'hCAFE, m_gnt:1'b1, default:'0},
        '{m_req:1'b1, m_addr:32'h400, m_be:4'hF, i_gnt:1'b1, busy:1'b1, default:'0});
    // Outstanding limit reached, slot freed by same-cycle response
    add("full_block", '{i_req:1'b1, i_addr:32'h500, m_gnt:1'b1, default:'0},
        '{busy:1'b1, default:'0});
    add("full_free", '{i_req:1'b1, i_addr:32'h500, m_gnt:1'b1, m_rvalid:1'b1, m_rdata:32'h11, default:'0},
        '{m_req:1'b1, m_addr:32'h500, m_be:4'hF, i_gnt:1'b1, d_rvalid:1'b1, d_rdata:32'h11, busy:1'b1,
          default:'0});
    add("order_1", '{m_rvalid:1'b1, m_rdata:32'h22, default:'0},
        '{i_rvalid:1'b1, i_rdata:32'h22, busy:1'b1, default:'0});
    add("order_2", '{m_rvalid:1'b1, m_rdata:32'h33, default:'0},
        '{i_rvalid:1'b1, i_rdata:32'h33, busy:1'b1, default:'0});
    add("idle_2", '{default:'0}, '{default:'0});

    // Reset: all outputs low even with requests present
    reset_n = 1'b0;
    drive('{i_req:1'b1, d_req:1'b1, m_gnt:1'b1, m_rvalid:1'b1, default:'0});
    #2;
    check("reset_outs", '{default:'0});
    @(negedge clk);
    drive('{default:'0});
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) step(vecs[k].name, vecs[k].stim, vecs[k].want);

    // Starvation: both ports always requesting, bus always granting
    grants = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive('{i_req:1'b1, i_addr:32'h900, d_req:1'b1, d_be:4'hF, d_addr:32'hA00,
              m_gnt:1'b1, m_rvalid:1'b1, default:'0});
      #2;
      g_want = (grants[k] == "I") ? 2'b10 : 2'b01;
      n_cmp++;
      if ({i_gnt, d_gnt} !== g_want) begin
        n_bad++;
        $display("FAIL starve_%0d: got i/d_gnt %b want %b", k, {i_gnt, d_gnt}, g_want);
      end
    end
    step("starve_drain", '{m_rvalid:1'b1, m_rdata:32'h5, default:'0},
         '{i_rvalid:1'b1, i_rdata:32'h5, busy:1'b1, default:'0});
    step("idle_3", '{default:'0}, '{default:'0});

    // Locked data owner drops its request: fetch takes the bus
    step("drop_0", '{d_req:1'b1, d_we:1'b1, d_be:4'hF, d_addr:32'h6000, default:'0},
         '{m_req:1'b1, m_addr:32'h6000, m_we:1'b1, m_be:4'hF, busy:1'b1, default:'0});
    step("drop_1", '{i_req:1'b1, i_addr:32'h6100, default:'0},
         '{m_req:1'b1, m_addr:32'h6100, m_be:4'hF, busy:1'b1, default:'0});
    step("drop_xfer", '{i_req:1'b1, i_addr:32'h6100, m_gnt:1'b1, default:'0},
         '{m_req:1'b1, m_addr:32'h6100, m_be:4'hF, i_gnt:1'b1, busy:1'b1, default:'0});
    step("drop_resp", '{m_rvalid:1'b1, m_rdata:32'h66, default:'0},
         '{i_rvalid:1'b1, i_rdata:32'h66, busy:1'b1, default:'0});

    // Reset with two data tags outstanding
    step("pre_rst_0", '{d_req:1'b1, d_be:4'hF, d_addr:32'h7000, m_gnt:1'b1, default:'0},
         '{m_req:1'b1, m_addr:32'h7000, m_be:4'hF, d_gnt:1'b1, busy:1'b1, default:'0});
    step("pre_rst_1", '{d_req:1'b1, d_be:4'hF, d_addr:32'h7004, m_gnt:1'b1, default:'0},
         '{m_req:1'b1, m_addr:32'h7004, m_be:4'hF, d_gnt:1'b1, busy:1'b1, default:'0});
    @(negedge clk);
    drive('{i_req:1'b1, i_addr:32'h7100, m_gnt:1'b1, default:'0});
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_mid", '{default:'0});
    @(negedge clk);
    reset_n = 1'b1;
    drive('{default:'0});
    step("post_rst_addr", '{i_req:1'b1, i_addr:32'h7100, m_gnt:1'b1, default:'0},
         '{m_req:1'b1, m_addr:32'h7100, m_be:4'hF, i_gnt:1'b1, busy:1'b1, default:'0});
    step("post_rst_resp", '{m_rvalid:1'b1, m_rdata:32'h77, default:'0},
         '{i_rvalid:1'b1, i_rdata:32'h77, busy:1'b1, default:'0});
    step("post_rst_idle", '{default:'0}, '{default:'0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
